// File: rtl/t02_mem_arbiter.sv
// t02_mem_arbiter: shares one single-port RAM between the instruction-fetch
// port and the data (load/store) port. Data wins by default. Defining
// T02_STARVE_GUARD_EN adds a counter that forces an instruction grant after
// STARVE_LIMIT consecutive data grants made while a fetch was waiting.
// Sequence per access: IDLE (grant) -> ISSUE -> WAIT (until !ram_busy) -> DONE.
module t02_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imem_req,
    input  logic [31:0] imem_addr,
    output logic        i_ready,
    output logic [31:0] imem_rdata,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_busy,
    output logic        arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        is_write_q, is_write_d;   // latched op: 1 = store
    logic        owner_data_q, owner_data_d; // latched owner: 1 = data port
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        data_req;
    logic        force_instr;
    logic        grant_instr;
    logic        grant_data;

    assign data_req = d_ren | d_wen;

`ifdef T02_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign force_instr = imem_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    // Starvation counter: counts data grants that overtook a waiting fetch
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == ST_IDLE) begin
            if (grant_instr || !imem_req) begin
                starve_cnt_d = '0;
            end else if (grant_data && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_instr = 1'b0;
`endif

    // Grant selection is only meaningful in IDLE; data wins unless forced
    assign grant_instr = (state_q == ST_IDLE) && imem_req && (force_instr || !data_req);
    assign grant_data  = (state_q == ST_IDLE) && data_req && !force_instr;

    // Next-state and latch updates; latched values are frozen after grant
    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        owner_data_d = owner_data_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        imem_rdata_d = imem_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    // both enables high is treated as a store
                    is_write_d   = d_wen;
                    owner_data_d = 1'b1;
                    addr_d       = d_addr;
                    wdata_d      = d_wdata;
                    state_d      = ST_ISSUE;
                end else if (grant_instr) begin
                    is_write_d   = 1'b0;
                    owner_data_d = 1'b0;
                    addr_d       = imem_addr;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // ram_busy cannot rise yet, so it is not looked at here
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!ram_busy) begin
                    if (!is_write_q) begin
                        if (owner_data_q) begin
                            d_rdata_d = ram_rdata;
                        end else begin
                            imem_rdata_d = ram_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            is_write_q   <= 1'b0;
            owner_data_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            imem_rdata_q <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            is_write_q   <= is_write_d;
            owner_data_q <= owner_data_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            imem_rdata_q <= imem_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Outputs decode straight from state, so an async reset drops them at once
    assign ram_ren    = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && !is_write_q;
    assign ram_wen    = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && is_write_q;
    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign i_ready    = (state_q == ST_DONE) && !owner_data_q;
    assign d_ready    = (state_q == ST_DONE) && owner_data_q;
    assign imem_rdata = imem_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign arb_busy   = (state_q != ST_IDLE);

endmodule
